// File: rtl/tmr_fi_pkg.sv
// tmr_fi_pkg: shared state encoding, mode codes and LFSR taps for the TMR fault injector
package tmr_fi_pkg;

    typedef enum logic [2:0] {IDLE, INJECT, WAIT, CHECK, DONE} state_t;

    localparam logic [1:0] MODE_NONE   = 2'd0;
    localparam logic [1:0] MODE_SINGLE = 2'd1;
    localparam logic [1:0] MODE_DOUBLE = 2'd2;
    localparam logic [1:0] MODE_RANDOM = 2'd3;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/tmr_fi_lfsr.sv
// tmr_fi_lfsr: free-running 16-bit Galois LFSR used to pick random lane/bit targets
module tmr_fi_lfsr
    import tmr_fi_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state_o
);

    logic [15:0] lfsr_q;

    // shift right every cycle, folding the taps in when a one drops out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= SEED;
        else        lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/tmr_fault_injector.sv
// tmr_fault_injector: drives three replica lanes, flips one bit in one or two lanes, checks voted outputs (random mode: TMR_FI_RANDOM_EN)
module tmr_fault_injector
    import tmr_fi_pkg::*;
#(
    parameter int          WIDTH       = 1,
    parameter int          HOLD_CYCLES = 1,
    parameter int          LAT         = 1,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    localparam int         BW          = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [1:0]       lane_sel,
    input  logic [BW-1:0]    bit_sel,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] out_0,
    output logic [WIDTH-1:0] out_1,
    output logic [WIDTH-1:0] out_2,
    input  logic [WIDTH-1:0] voted_in_0,
    input  logic [WIDTH-1:0] voted_in_1,
    input  logic [WIDTH-1:0] voted_in_2,
    output logic             busy,
    output logic             done,
    output logic             masked,
    output logic [15:0]      inject_count
);

    localparam logic [15:0] HOLD_M1 = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] LAT_M2  = 16'((LAT > 1) ? LAT - 2 : 0);

    state_t           state_q;
    logic [15:0]      cnt_q;
    logic [WIDTH-1:0] golden_q;
    logic [WIDTH-1:0] flip_q;
    logic [2:0]       lanes_q;
    logic [WIDTH-1:0] out_q [3];
    logic             busy_q;
    logic             done_q;
    logic             masked_q;
    logic [15:0]      inject_count_q;

    logic [1:0]       sel_lane;
    logic [BW-1:0]    sel_bit;
    logic [2:0]       lane_one;
    logic [2:0]       lanes_d;
    logic [WIDTH-1:0] flip_d;

`ifdef TMR_FI_RANDOM_EN
    logic [15:0] lfsr;

    tmr_fi_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .state_o (lfsr)
    );
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
`endif

    // target selection: lane set and one-hot bit; invalid lane or bit gives a null run
    always_comb begin
        sel_lane = lane_sel;
        sel_bit  = bit_sel;
`ifdef TMR_FI_RANDOM_EN
        if (mode == MODE_RANDOM) begin
            sel_lane = (lfsr[1:0] == 2'd3) ? 2'd0 : lfsr[1:0];
            sel_bit  = BW'(32'(lfsr[15:2]) % 32'(WIDTH));
        end
`endif
        lane_one = (sel_lane == 2'd0) ? 3'b001 :
                   (sel_lane == 2'd1) ? 3'b010 :
                   (sel_lane == 2'd2) ? 3'b100 : 3'b000;
        lanes_d  = (mode == MODE_NONE || 32'(sel_bit) >= 32'(WIDTH)) ? 3'b000 :
                   (mode == MODE_DOUBLE) ? (lane_one | {lane_one[1:0], lane_one[2]}) : lane_one;
        flip_d   = WIDTH'(1) << sel_bit;
    end

    // run sequencer with registered lane drive and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            golden_q       <= '0;
            flip_q         <= '0;
            lanes_q        <= '0;
            for (int k = 0; k < 3; k++) out_q[k] <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            masked_q       <= 1'b0;
            inject_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    for (int k = 0; k < 3; k++) out_q[k] <= data_in;
                    if (start) begin
                        golden_q <= data_in;
                        lanes_q  <= lanes_d;
                        flip_q   <= flip_d;
                        cnt_q    <= HOLD_M1;
                        busy_q   <= 1'b1;
                        state_q  <= INJECT;
                    end
                end
                INJECT: begin
                    for (int k = 0; k < 3; k++) out_q[k] <= golden_q ^ (lanes_q[k] ? flip_q : '0);
                    if (cnt_q == '0) begin
                        cnt_q   <= LAT_M2;
                        state_q <= (LAT == 1) ? CHECK : WAIT;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                WAIT: begin
                    for (int k = 0; k < 3; k++) out_q[k] <= golden_q;
                    if (cnt_q == '0) state_q <= CHECK;
                    else             cnt_q   <= cnt_q - 16'd1;
                end
                CHECK: begin
                    for (int k = 0; k < 3; k++) out_q[k] <= golden_q;
                    masked_q <= (voted_in_0 == golden_q) && (voted_in_1 == golden_q) && (voted_in_2 == golden_q);
                    if (|lanes_q && inject_count_q != 16'hFFFF) inject_count_q <= inject_count_q + 16'd1;
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
                default: begin
                    for (int k = 0; k < 3; k++) out_q[k] <= golden_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_0        = out_q[0];
    assign out_1        = out_q[1];
    assign out_2        = out_q[2];
    assign busy         = busy_q;
    assign done         = done_q;
    assign masked       = masked_q;
    assign inject_count = inject_count_q;

endmodule

// File: tb/tb_tmr_fault_injector.sv
// tb_tmr_fault_injector: table-driven and randomized checks of the TMR fault injector against a voter model
module tb_tmr_fault_injector;

    localparam int W = 6;
    localparam int H = 3;
    localparam int L = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   mode = '0;
    logic [1:0]   lane_sel = '0;
    logic [2:0]   bit_sel = '0;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] o0, o1, o2;
    logic [W-1:0] v0, v1, v2;
    logic         busy, done, masked;
    logic [15:0]  inject_count;
    bit           vmode = 1'b0;

    int           n_vec = 0;
    int           n_err = 0;
    logic [15:0]  exp_count = '0;

    tmr_fault_injector #(.WIDTH(W), .HOLD_CYCLES(H), .LAT(L)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .mode         (mode),
        .lane_sel     (lane_sel),
        .bit_sel      (bit_sel),
        .data_in      (data_in),
        .out_0        (o0),
        .out_1        (o1),
        .out_2        (o2),
        .voted_in_0   (v0),
        .voted_in_1   (v1),
        .voted_in_2   (v2),
        .busy         (busy),
        .done         (done),
        .masked       (masked),
        .inject_count (inject_count)
    );

    always #5 clk = ~clk;

    // DUT model: one register stage (LAT=2) after either a bitwise majority voter or per-lane pass-through
    logic [W-1:0] maj;
    assign maj = (o0 & o1) | (o1 & o2) | (o0 & o2);
    always @(posedge clk) begin
        v0 <= vmode ? o0 : maj;
        v1 <= vmode ? o1 : maj;
        v2 <= vmode ? o2 : maj;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] model_lanes(input int m, input int l, input int b);
        logic [2:0] s = 3'b000;
        if (m == 0 || l == 3 || b >= W) return 3'b000;
        s[l] = 1'b1;
        if (m == 2) s[(l + 1) % 3] = 1'b1;
        return s;
    endfunction

    task automatic run(input logic [1:0] m, input logic [1:0] l, input logic [2:0] b, input logic [W-1:0] d,
                       input bit vm, input logic [2:0] xl, input bit xm, input bit dup);
        int k;
        int fl[3];
        int bad;
        logic [W-1:0] ov[3];
        logic [W-1:0] flipv;
        vmode = vm;
        @(negedge clk);
        data_in = d; mode = m; lane_sel = l; bit_sel = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        data_in = ~d;
        flipv = d ^ (W'(1) << b);
        fl = '{0, 0, 0};
        bad = 0;
        k = 1;
        check("busy_after_start", 32'(busy), 32'd1);
        while (done !== 1'b1 && k < 30) begin
            start = (dup && k == 2);
            ov = '{o0, o1, o2};
            for (int i = 0; i < 3; i++)
                if (ov[i] !== d) begin
                    if (ov[i] === flipv) fl[i]++;
                    else bad++;
                end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("done_latency", 32'(k), 32'(H + L + 1));
        for (int i = 0; i < 3; i++) check($sformatf("lane%0d_flip_cycles", i), 32'(fl[i]), xl[i] ? 32'(H) : 32'd0);
        check("lane_bad_values", 32'(bad), 32'd0);
        check("masked", 32'(masked), 32'(xm));
        if (xl != 3'b000 && exp_count != 16'hFFFF) exp_count++;
        check("inject_count", 32'(inject_count), 32'(exp_count));
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    typedef struct {
        logic [1:0]   m, l;
        logic [2:0]   b;
        logic [W-1:0] d;
        bit           vm;
        logic [2:0]   xl;
        bit           xm;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int dn;
        logic [1:0] m, l;
        logic [2:0] b, xl;
        bit vm;
        logic [W-1:0] d;

        tbl[0] = '{2'd1, 2'd1, 3'd0, 6'h3F, 1'b0, 3'b010, 1'b1};
        tbl[1] = '{2'd2, 2'd2, 3'd0, 6'h3F, 1'b0, 3'b101, 1'b0};
        tbl[2] = '{2'd1, 2'd3, 3'd0, 6'h3F, 1'b0, 3'b000, 1'b1};
        tbl[3] = '{2'd0, 2'd0, 3'd3, 6'h2A, 1'b1, 3'b000, 1'b1};
        tbl[4] = '{2'd1, 2'd0, 3'd6, 6'h15, 1'b1, 3'b000, 1'b1};
        tbl[5] = '{2'd3, 2'd2, 3'd5, 6'h00, 1'b1, 3'b100, 1'b0};
        tbl[6] = '{2'd1, 2'd0, 3'd2, 6'h3C, 1'b1, 3'b001, 1'b0};
        tbl[7] = '{2'd2, 2'd1, 3'd4, 6'h11, 1'b0, 3'b110, 1'b0};
        tbl[8] = '{2'd2, 2'd3, 3'd1, 6'h07, 1'b0, 3'b000, 1'b1};
        tbl[9] = '{2'd2, 2'd2, 3'd7, 6'h3F, 1'b0, 3'b000, 1'b1};

        data_in = 6'h01;
        repeat (2) @(negedge clk);
        check("rst_out0", 32'(o0), 32'd0);
        check("rst_out1", 32'(o1), 32'd0);
        check("rst_out2", 32'(o2), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_masked", 32'(masked), 32'd0);
        check("rst_count", 32'(inject_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("pass_out0", 32'(o0), 32'd1);
        check("pass_out1", 32'(o1), 32'd1);
        check("pass_out2", 32'(o2), 32'd1);

        for (int i = 0; i < 10; i++)
            run(tbl[i].m, tbl[i].l, tbl[i].b, tbl[i].d, tbl[i].vm, tbl[i].xl, tbl[i].xm, 1'b0);

        for (int i = 0; i < 40; i++) begin
            m  = 2'($urandom_range(0, 3));
            l  = 2'($urandom_range(0, 3));
            b  = 3'($urandom_range(0, 7));
            d  = W'($urandom);
            vm = 1'($urandom_range(0, 1));
            xl = model_lanes(int'(m == 2'd3 ? 2'd1 : m), int'(l), int'(b));
            run(m, l, b, d, vm, xl, vm ? (xl == 3'b000) : ($countones(xl) < 2), 1'b0);
        end

        run(2'd1, 2'd1, 3'd3, 6'h2D, 1'b1, 3'b010, 1'b0, 1'b1);
        dn = 0;
        repeat (10) begin
            if (done === 1'b1) dn++;
            @(negedge clk);
        end
        check("start_while_busy_ignored", 32'(dn), 32'd0);
        check("count_after_ignored_start", 32'(inject_count), 32'(exp_count));

        vmode = 1'b0;
        @(negedge clk);
        data_in = 6'h3F; mode = 2'd1; lane_sel = 2'd0; bit_sel = 3'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out0", 32'(o0), 32'd0);
        check("abort_out1", 32'(o1), 32'd0);
        check("abort_out2", 32'(o2), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_count", 32'(inject_count), 32'd0);
        exp_count = '0;
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (10) begin
            if (done === 1'b1 || busy === 1'b1) dn++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(dn), 32'd0);

        force dut.inject_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.inject_count_q;
        exp_count = 16'hFFFE;
        run(2'd1, 2'd2, 3'd1, 6'h0F, 1'b0, 3'b100, 1'b1, 1'b0);
        run(2'd2, 2'd0, 3'd2, 6'h30, 1'b0, 3'b011, 1'b0, 1'b0);
        check("count_saturated", 32'(inject_count), 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tmr_fault_injector.md
Name: tmr_fault_injector

Overview:
Stimulus and checking end of a triplicated datapath such as a GTMR cell with majority voters.
- Takes one golden data word and fans it out as three registered replica lanes.
- On command, flips one chosen bit in one or two lanes for a set number of cycles.
- After the DUT latency, samples the three voted outputs and reports whether the upset was masked.
- Used in the fault-tolerance bench and in on-chip self-test wrappers around TMR blocks.

Parameters:
WIDTH, 1, replica/data width in bits
HOLD_CYCLES, 1, cycles the flip is held on the lanes (>=1)
LAT, 1, cycles from a lane change to its effect on voted_in_* (>=1)
LFSR_SEED, 16'hACE1, nonzero seed for the random selector (optional feature only)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to run one injection
mode  in  2  0 none, 1 single lane, 2 double lane, 3 random single lane
lane_sel  in  2  target lane 0..2; 3 = invalid
bit_sel  in  max(1,$clog2(WIDTH))  bit index to flip
data_in  in  WIDTH  golden data
out_0, out_1, out_2  out  WIDTH each  replica lanes to DUT
voted_in_0, voted_in_1, voted_in_2  in  WIDTH each  DUT voter outputs
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse at end of check
masked  out  1  result of last run: all voted_in equal golden
inject_count  out  16  runs with a real flip, saturating at 16'hFFFF

Behaviour:
- Reset (async, rst_n=0): out_* = 0, busy = 0, done = 0, masked = 0, inject_count = 0, state IDLE, LFSR = LFSR_SEED. Reset mid-run aborts the run with no done pulse.
- IDLE:
  - out_k <= data_in every cycle (one-cycle registered pass-through).
  - start=1: capture golden_q <= data_in, mask_k <= computed flip vector, go to INJECT.
  - start while busy is ignored.
- Flip vector, with onehot = 1<<bit_sel:
  - mode 1: lane lane_sel.
  - mode 2: lanes lane_sel and (lane_sel+1) mod 3.
  - mode 0, lane_sel=3 in mode 1/2, or bit_sel>=WIDTH: all-zero mask ("null run").
- INJECT: out_k <= golden_q ^ mask_k for HOLD_CYCLES cycles (down-counter), then go to WAIT.
- WAIT: out_k <= golden_q (clean) for LAT-1 cycles; LAT=1 skips WAIT and goes straight to CHECK.
- CHECK, one cycle:
  - masked <= (voted_in_0==golden_q) & (voted_in_1==golden_q) & (voted_in_2==golden_q).
  - Timing: this samples voted_in LAT cycles after the last injected lane value was driven.
  - done=1 on the next cycle, in DONE.
  - inject_count increments if the mask is nonzero; it saturates.
  - Then return to IDLE.
- Simultaneous start and done: the new start is accepted only in IDLE, so it is ignored in the DONE cycle.
- masked holds its value until the next CHECK.

Optional Feature:
TMR_FI_RANDOM_EN
- Defined:
  - Adds a 16-bit Galois LFSR (taps 16'hB400) that advances every cycle.
  - mode 3 takes lane = lfsr[1:0] mod 3 and bit = lfsr[15:2] mod WIDTH at start.
- Not defined:
  - No LFSR is built and LFSR_SEED is unused.
  - mode 3 behaves exactly as mode 1.

Decomposition:
- Package tmr_fi_pkg:
  - state enum {IDLE, INJECT, WAIT, CHECK, DONE}
  - mode constants MODE_NONE, MODE_SINGLE, MODE_DOUBLE, MODE_RANDOM
  - LFSR tap constant
- One sub-module, tmr_fi_lfsr: seed parameter, clk/rst_n, 16-bit state output; instantiated only under TMR_FI_RANDOM_EN.

Test Plan:
- Reset: rst_n low with data_in=1 -> out_*=0, busy=0, inject_count=0. After release, out_*=1 one cycle later.
- Single flip, DUT GTMR_AND with inputs port_in_1_*=1: data_in=1, mode=1, lane_sel=1, bit_sel=0 -> out_1=0 for 1 cycle, others 1; done after CHECK; masked=1; inject_count=1.
- Double flip: same setup with mode=2, lane_sel=2 -> lanes 2 and 0 flipped, voters output 0, masked=0, inject_count=2.
- Null run: mode=1, lane_sel=3 -> no lane differs from golden, masked=1, inject_count unchanged.
- Busy and reset abort:
  - start pulsed during INJECT -> ignored, exactly one done.
  - rst_n low during WAIT -> no done, outputs 0, state IDLE.
- HOLD_CYCLES=3, LAT=2: flip visible exactly 3 cycles; CHECK occurs 2 cycles after the last flipped value; inject_count at 16'hFFFF stays 16'hFFFF after a further run.
